// File: rtl/io_port_pkg.sv
// Shared constants and types for the Datapath I/O port blocks.
package io_port_pkg;

    localparam int IO_WORD_WIDTH_DEFAULT   = 36;
    localparam int IO_SOURCE_COUNT_DEFAULT = 4;

    // Empty/Full flag encoding seen by the Datapath on io_read_EF.
    typedef enum logic {
        IO_EF_EMPTY = 1'b0,
        IO_EF_FULL  = 1'b1
    } io_ef_e;

endpackage

// File: rtl/io_read_port_arbiter_if.sv
// Producer-side valid/ready bundle plus the Datapath read-port slice.
interface io_read_port_arbiter_if
    import io_port_pkg::*;
#(
    parameter int WORD_WIDTH      = IO_WORD_WIDTH_DEFAULT,
    parameter int SOURCE_COUNT    = IO_SOURCE_COUNT_DEFAULT,
    parameter int SOURCE_ID_WIDTH = 2
);

    logic [SOURCE_COUNT-1:0]            src_valid;
    logic [SOURCE_COUNT*WORD_WIDTH-1:0] src_data;
    logic [SOURCE_COUNT-1:0]            src_enable;
    logic [SOURCE_COUNT-1:0]            src_ready;
    logic                               io_rden;
    logic                               io_read_EF;
    logic [WORD_WIDTH-1:0]              io_read_data;
    logic [SOURCE_ID_WIDTH-1:0]         io_read_src;

    // Producers and the Datapath drive the arbiter.
    modport master (
        output src_valid, src_data, src_enable, io_rden,
        input  src_ready, io_read_EF, io_read_data, io_read_src
    );

    // The arbiter itself.
    modport slave (
        input  src_valid, src_data, src_enable, io_rden,
        output src_ready, io_read_EF, io_read_data, io_read_src
    );

endinterface

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: the search starts just above last_grant
// and wraps, done as a lowest-set-bit scan over {req, req above last_grant}.
module round_robin_arbiter #(
    parameter int REQ_COUNT = 4,
    parameter int IDX_WIDTH = $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    input  logic                 enable,
    output logic [REQ_COUNT-1:0] grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 any_grant
);

    localparam int unsigned SPAN = 2 * REQ_COUNT;

    logic [REQ_COUNT-1:0] upper_mask;
    logic [SPAN-1:0]      dbl_req;

    // Positions strictly above the previous winner get first look.
    always_comb begin
        upper_mask = '0;
        for (int unsigned i = 0; i < REQ_COUNT; i++) begin
            upper_mask[i] = (IDX_WIDTH'(i) > last_grant);
        end
    end

    assign dbl_req = {req, req & upper_mask};

    // Lowest set bit of the double-width vector, folded back modulo REQ_COUNT.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int unsigned i = 0; i < SPAN; i++) begin
            if (!any_grant && dbl_req[i]) begin
                any_grant = 1'b1;
                grant_idx = IDX_WIDTH'(i % REQ_COUNT);
            end
        end
        if (!enable) begin
            any_grant = 1'b0;
            grant_idx = '0;
        end
        grant = any_grant ? (REQ_COUNT'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/io_read_port_arbiter.sv
// Shares one Datapath I/O read port between several valid/ready producers,
// holding one word and the ID of the source that produced it.
module io_read_port_arbiter
    import io_port_pkg::*;
#(
    parameter int WORD_WIDTH      = IO_WORD_WIDTH_DEFAULT,
    parameter int SOURCE_COUNT    = IO_SOURCE_COUNT_DEFAULT,
    parameter int SOURCE_ID_WIDTH = 2
) (
    input logic                    clock,
    input logic                    reset,
    io_read_port_arbiter_if.slave  bus
);

    io_ef_e                     ef_q;
    logic [WORD_WIDTH-1:0]      data_q;
    logic [SOURCE_ID_WIDTH-1:0] src_q;
    logic [SOURCE_ID_WIDTH-1:0] last_grant_q;

    logic [SOURCE_COUNT-1:0]    req;
    logic                       consume;
    logic                       load_ok;
    logic [SOURCE_COUNT-1:0]    grant;
    logic [SOURCE_ID_WIDTH-1:0] grant_idx;
    logic                       any_grant;
    logic [WORD_WIDTH-1:0]      src_word [SOURCE_COUNT];

    for (genvar i = 0; i < SOURCE_COUNT; i++) begin : g_word
        assign src_word[i] = bus.src_data[i*WORD_WIDTH +: WORD_WIDTH];
    end

    assign req     = bus.src_valid & bus.src_enable;
    assign consume = bus.io_rden & (ef_q == IO_EF_FULL);
    assign load_ok = (ef_q == IO_EF_EMPTY) | consume;

    // Reset gates the enable so no handshake can complete while it is held.
    round_robin_arbiter #(
        .REQ_COUNT (SOURCE_COUNT),
        .IDX_WIDTH (SOURCE_ID_WIDTH)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .enable     (load_ok & ~reset),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    assign bus.src_ready    = grant;
    assign bus.io_read_EF   = (ef_q == IO_EF_FULL);
    assign bus.io_read_data = data_q;
    assign bus.io_read_src  = src_q;

    // Holding register: a load wins over a consume so back-to-back words stream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ef_q   <= IO_EF_EMPTY;
            data_q <= '0;
            src_q  <= '0;
        end else if (any_grant) begin
            ef_q   <= IO_EF_FULL;
            data_q <= src_word[grant_idx];
            src_q  <= grant_idx;
        end else if (consume) begin
            ef_q   <= IO_EF_EMPTY;
        end
    end

    // Round-robin pointer: reset value makes source 0 the first to be served.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= SOURCE_ID_WIDTH'(SOURCE_COUNT - 1);
        end else if (any_grant) begin
            last_grant_q <= grant_idx;
        end
    end

endmodule
